instr_fetch_unit: RTL and testbench

Instruction fetch front-end for KGP-RISC: it generates sequential fetch addresses, issues read requests to instruction memory, and buffers returned words with their PCs in a small in-order queue for decode. It consumes the redirect target produced by the program-counter logic (register jump, 26-bit jump, reset vector). On a redirect it flushes the queue and discards any stale in-flight responses, so decode only ever sees the correct instruction stream.

---
 rtl/kgp_fetch_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 82 ++++++++
 rtl/instr_fetch_unit.sv | 112 +++++++++++
 tb/tb_instr_fetch_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/kgp_fetch_pkg.sv
// Shared types and constants for the KGP-RISC instruction fetch front-end.
package kgp_fetch_pkg;
    localparam int ADDR_W  = 32;
    localparam int INSTR_W = 32;
    localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] data;
    } fetch_entry_t;

    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] pc);
        return {pc[ADDR_W-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous in-order FIFO with flush; head is read straight from registered storage.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [W-1:0]     data_i,
    input  logic             pop_i,
    output logic [W-1:0]     head_o,
    output logic [CNT_W-1:0] count_o
);
    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_s, do_pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    assign do_push_s = push_i && (count_q != CNT_W'(DEPTH));
    assign do_pop_s  = pop_i && (count_q != CNT_W'(0));
    assign head_o    = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    // Pointer and occupancy next-state; flush wins over push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = CNT_W'(0);
        end else begin
            if (do_push_s) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= CNT_W'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; cleared on reset so the head reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {W{1'b0}};
            end
        end else if (do_push_s && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front-end: issues sequential imem reads, queues returned words with their PCs,
// and on redirect flushes the queue and drops responses to reads issued before it.
module instr_fetch_unit
    import kgp_fetch_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter int                MAX_OUT  = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_data,
    output logic [ADDR_W-1:0]  instr_pc
);
    localparam int QCNT_W = $clog2(DEPTH + 1);
    localparam int OCNT_W = $clog2(MAX_OUT + 1);
    localparam int SUM_W  = $clog2(2 * DEPTH + 1);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [OCNT_W-1:0] stale_q, stale_d;
    logic [OCNT_W-1:0] inflight_s, live_s;
    logic [QCNT_W-1:0] q_count_s;
    logic [SUM_W-1:0]  occupancy_s;
    logic [ADDR_W-1:0] trk_pc_s;
    logic              run_q;
    logic              issue_s, req_fire_s, rsp_keep_s, pop_s;
    fetch_entry_t      rsp_entry_s, head_s;

    assign live_s      = inflight_s - stale_q;
    assign occupancy_s = SUM_W'(q_count_s) + SUM_W'(live_s);
    // run_q keeps the request low while reset is held and for the release cycle.
    assign issue_s     = run_q && !redirect_valid
                         && (inflight_s < OCNT_W'(MAX_OUT))
                         && (occupancy_s < SUM_W'(DEPTH));
    assign req_fire_s  = issue_s && imem_req_ready;
    assign rsp_keep_s  = imem_rsp_valid && (stale_q == OCNT_W'(0)) && !redirect_valid;
    assign pop_s       = instr_valid && instr_ready;

    assign imem_req_valid   = issue_s;
    assign imem_req_addr    = fetch_pc_q;
    assign rsp_entry_s.pc   = trk_pc_s;
    assign rsp_entry_s.data = imem_rsp_data;
    assign instr_valid      = (q_count_s != QCNT_W'(0));
    assign instr_data       = head_s.data;
    assign instr_pc         = head_s.pc;

    // Fetch PC and stale-response bookkeeping; redirect has priority.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        stale_d    = stale_q;
        if (redirect_valid) begin
            fetch_pc_d = align_pc(redirect_pc);
            stale_d    = inflight_s - (imem_rsp_valid ? OCNT_W'(1) : OCNT_W'(0));
        end else begin
            if (req_fire_s) begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            if (imem_rsp_valid && (stale_q != OCNT_W'(0))) begin
                stale_d = stale_q - OCNT_W'(1);
            end else begin
                stale_d = stale_q;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            stale_q    <= OCNT_W'(0);
            run_q      <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            stale_q    <= stale_d;
            run_q      <= 1'b1;
        end
    end

    // Issued addresses in request order; never flushed, so its count is the in-flight total.
    fetch_fifo #(.DEPTH(MAX_OUT), .W(ADDR_W)) u_pc_trk (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (1'b0),
        .push_i  (req_fire_s),
        .data_i  (fetch_pc_q),
        .pop_i   (imem_rsp_valid),
        .head_o  (trk_pc_s),
        .count_o (inflight_s)
    );

    fetch_fifo #(.DEPTH(DEPTH), .W($bits(fetch_entry_t))) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (redirect_valid),
        .push_i  (rsp_keep_s),
        .data_i  (rsp_entry_s),
        .pop_i   (pop_s),
        .head_o  (head_s),
        .count_o (q_count_s)
    );
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an in-order latency-configurable imem model
// and a queue of expected PCs consumed as decode pops instructions.
module tb_instr_fetch_unit;
    localparam logic [31:0] KEY = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;

    int checks = 0;
    int fails  = 0;
    int w;
    logic [31:0] sbq[$];

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t mq[$];
    int    mem_lat = 1;
    int    acc_cnt;
    int    cyc;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc)
    );

    always #5 clk = ~clk;

    // Instruction memory: in order, one response per cycle, word = addr ^ KEY, reset with the DUT.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            acc_cnt        <= 0;
            cyc            <= 0;
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= 32'd0;
        end else begin
            cyc <= cyc + 1;
            if (imem_req_valid && imem_req_ready) begin
                mq.push_back('{imem_req_addr, cyc + mem_lat});
                acc_cnt <= acc_cnt + 1;
            end
            imem_rsp_valid <= 1'b0;
            if (mq.size() > 0 && mq[0].due <= cyc + 1) begin
                imem_rsp_valid <= 1'b1;
                imem_rsp_data  <= mq[0].addr ^ KEY;
                void'(mq.pop_front());
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for a valid head, checks it against the scoreboard, pops it for one cycle.
    task automatic pop_check(input string tag, output int waited);
        logic [31:0] e;
        waited = 0;
        while (!instr_valid && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        if (!instr_valid) begin
            chk({tag, "_timeout"}, 32'(instr_valid), 32'd1);
        end else begin
            e = (sbq.size() > 0) ? sbq.pop_front() : 32'hDEAD_BEEF;
            chk({tag, "_pc"}, instr_pc, e);
            chk({tag, "_data"}, instr_data, e ^ KEY);
            instr_ready = 1'b1;
            @(negedge clk);
            instr_ready = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic redirect(input logic [31:0] tgt);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr", imem_req_addr, 32'h0000_0000);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr_data", instr_data, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);

        // Streaming from reset, one instruction per cycle.
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) sbq.push_back(32'(4 * i));
        pop_check("t1_0", w);
        for (int i = 1; i < 4; i++) begin
            pop_check($sformatf("t1_%0d", i), w);
            chk($sformatf("t1_consec_%0d", i), 32'(w), 32'd0);
        end

        // Decode back-pressure fills the queue, then drains in order.
        do_reset();
        repeat (20) @(negedge clk);
        chk("t2_accepted", 32'(acc_cnt), 32'd4);
        chk("t2_head_valid", 32'(instr_valid), 32'd1);
        chk("t2_head_pc", instr_pc, 32'd0);
        for (int i = 0; i < 5; i++) sbq.push_back(32'(4 * i));
        for (int i = 0; i < 5; i++) pop_check($sformatf("t2_%0d", i), w);

        // Redirect with two slow reads outstanding; both responses must be dropped.
        mem_lat = 4;
        do_reset();
        repeat (3) @(negedge clk);
        chk("t3_inflight", 32'(acc_cnt), 32'd2);
        chk("t3_empty", 32'(instr_valid), 32'd0);
        redirect(32'h0000_0103);
        chk("t3_req_addr", imem_req_addr, 32'h0000_0100);
        sbq.push_back(32'h0000_0100);
        sbq.push_back(32'h0000_0104);
        pop_check("t3_0", w);
        pop_check("t3_1", w);

        // Redirect coinciding with a response and a pop.
        mem_lat     = 1;
        instr_ready = 1'b1;
        repeat (12) @(negedge clk);
        chk("t4_pre_valid", 32'(instr_valid), 32'd1);
        chk("t4_pre_rsp", 32'(imem_rsp_valid), 32'd1);
        redirect(32'h0000_0200);
        instr_ready = 1'b0;
        chk("t4_flushed", 32'(instr_valid), 32'd0);
        sbq.push_back(32'h0000_0200);
        sbq.push_back(32'h0000_0204);
        pop_check("t4_0", w);
        chk("t4_latency", 32'(w), 32'd2);
        pop_check("t4_1", w);
        chk("t4_consec", 32'(w), 32'd0);

        // Address wrap at the top of the address space.
        repeat (6) @(negedge clk);
        sbq.push_back(32'hFFFF_FFF8);
        sbq.push_back(32'hFFFF_FFFC);
        sbq.push_back(32'h0000_0000);
        redirect(32'hFFFF_FFF8);
        chk("t5_req_addr", imem_req_addr, 32'hFFFF_FFF8);
        pop_check("t5_0", w);
        pop_check("t5_1", w);
        pop_check("t5_2", w);

        // Reset asserted while a request is stalled by memory.
        imem_req_ready = 1'b0;
        redirect(32'h0000_0400);
        repeat (3) @(negedge clk);
        chk("t6_stall_valid", 32'(imem_req_valid), 32'd1);
        chk("t6_stall_addr", imem_req_addr, 32'h0000_0400);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("t6_rst_req_addr", imem_req_addr, 32'h0000_0000);
        chk("t6_rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("t6_rst_instr_data", instr_data, 32'd0);
        chk("t6_rst_instr_pc", instr_pc, 32'd0);
        @(negedge clk);
        rst_n          = 1'b1;
        imem_req_ready = 1'b1;
        @(negedge clk);
        chk("t6_first_valid", 32'(imem_req_valid), 32'd1);
        chk("t6_first_addr", imem_req_addr, 32'h0000_0000);
        sbq.push_back(32'h0000_0000);
        pop_check("t6_0", w);
        chk("sb_drained", 32'(sbq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
